// File: rtl/keypad_matrix_scanner_pkg.sv
// keypad_matrix_scanner_pkg: shared FSM encodings, key codes and {col,row}->key_code mapping
package keypad_matrix_scanner_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'hF;
  function automatic logic one_low(input logic [3:0] r);
    logic [3:0] a;
    a = ~r;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction
  function automatic logic [3:0] key_of(input logic [1:0] col, input logic [3:0] r);
    logic [1:0] row;
    row = !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
    return row != 2'd3 ? {2'b0, row} * 4'd3 + {2'b0, col} + 4'd1 :
           col == 2'd0 ? KEY_STAR : col == 2'd1 ? 4'd0 : KEY_HASH;
  endfunction
endpackage

// File: rtl/keypad_sync2.sv
// keypad_sync2: 4-bit two-flop synchroniser for the row returns, resets to idle (all high)
module keypad_sync2 (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [3:0] d,
  output logic [3:0] q
);
  logic [3:0] s1;
  // two flop stages so downstream logic only ever sees a settled row pattern
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      s1 <= 4'hF;
      q  <= 4'hF;
    end else begin
      s1 <= d;
      q  <= s1;
    end
endmodule

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: scans a 4x3 keypad, debounces presses/releases, drives a one-hot digit bus
module keypad_matrix_scanner
  import keypad_matrix_scanner_pkg::*;
#(
  parameter int SCAN_DWELL      = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_valid
);
  localparam int DW = SCAN_DWELL > 1 ? $clog2(SCAN_DWELL) : 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  state_t        state, state_d;
  logic [DW-1:0] dwell, dwell_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic [3:0]    rs, cand, cand_d, code_d, code_new;
  logic [2:0]    col_d, col_next;
  logic [1:0]    col_idx;
  logic [9:0]    keypad_d;
  logic          valid_d;
  keypad_sync2 u_sync (.clk(clk), .clear_n(clear_n), .d(row_n), .q(rs));
  assign col_next = {col_n[1:0], col_n[2]};
  assign col_idx  = col_n == 3'b110 ? 2'd0 : col_n == 3'b101 ? 2'd1 : 2'd2;
  assign cnt_inc  = cnt + CW'(1);
  assign code_new = key_of(col_idx, cand);
  // state register plus column ring, counters and registered outputs
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      state     <= SCAN;
      dwell     <= '0;
      cnt       <= '0;
      cand      <= 4'hF;
      col_n     <= 3'b110;
      keypad    <= '0;
      key_code  <= KEY_NONE;
      key_valid <= 1'b0;
    end else begin
      state     <= state_d;
      dwell     <= dwell_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      col_n     <= col_d;
      keypad    <= keypad_d;
      key_code  <= code_d;
      key_valid <= valid_d;
    end
  // next-state: dwell/sample in SCAN, confirm candidate in DEBOUNCE, wait for stable release in HELD
  always_comb begin
    state_d  = state;
    dwell_d  = dwell;
    cnt_d    = cnt;
    cand_d   = cand;
    col_d    = col_n;
    keypad_d = keypad;
    code_d   = key_code;
    valid_d  = 1'b0;
    case (state)
      SCAN: begin
        dwell_d = dwell == DW'(SCAN_DWELL - 1) ? '0 : dwell + DW'(1);
        if (dwell == DW'(SCAN_DWELL - 1)) begin
          if (one_low(rs)) begin
            cand_d  = rs;
            cnt_d   = '0;
            state_d = DEBOUNCE;
          end else
            col_d = col_next;
        end
      end
      DEBOUNCE: begin
        if (rs != cand) begin
          state_d = SCAN;
          col_d   = col_next;
          dwell_d = '0;
        end else if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
          state_d  = HELD;
          cnt_d    = '0;
          code_d   = code_new;
          keypad_d = code_new < 4'd10 ? 10'd1 << code_new : 10'd0;
          valid_d  = 1'b1;
        end else
          cnt_d = cnt_inc;
      end
      HELD: begin
        cnt_d = rs == 4'hF ? cnt_inc : '0;
        if (rs == 4'hF && cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
          state_d  = SCAN;
          cnt_d    = '0;
          dwell_d  = '0;
          col_d    = col_next;
          keypad_d = '0;
          code_d   = KEY_NONE;
        end
      end
      default: state_d = SCAN;
    endcase
  end
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed keypad presses against hand-computed outputs
module tb_keypad_matrix_scanner;
  logic        clk = 1'b0;
  logic        clear_n;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [9:0]  keypad;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [11:0] pr;
  logic [3:0]  force_n;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vcount = 0;
  int          vbase;
  int          trans;
  logic [2:0]  prev;

  keypad_matrix_scanner dut (
    .clk(clk), .clear_n(clear_n), .row_n(row_n), .col_n(col_n),
    .keypad(keypad), .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // passive membrane matrix: a pressed key shorts its row to its column when that column is driven low
  always_comb begin
    row_n = force_n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pr[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(posedge clk) if (key_valid) vcount++;

  function automatic logic [11:0] k(input int r, input int c);
    return 12'd1 << (r * 3 + c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int w = 0;
    while (key_valid !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_valid"}, {31'd0, key_valid}, 32'd1);
  endtask

  initial begin
    clear_n = 1'b0;
    pr      = '0;
    force_n = 4'hF;
    cyc(2);
    chk("rst_col", {29'd0, col_n}, 32'b110);
    chk("rst_keypad", {22'd0, keypad}, 32'd0);
    chk("rst_code", {28'd0, key_code}, 32'hF);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    clear_n = 1'b1;
    @(negedge clk);
    force_n = 4'b1110;
    @(negedge clk);
    force_n = 4'hF;
    cyc(2);
    chk("bounce_hold", {29'd0, col_n}, 32'b110);
    cyc(1);
    chk("bounce_drop", {29'd0, col_n}, 32'b101);
    cyc(10);
    chk("bounce_novalid", vcount, 32'd0);

    pr = k(1, 1);
    wait_valid("k5");
    chk("k5_code", {28'd0, key_code}, 32'd5);
    chk("k5_keypad", {22'd0, keypad}, 32'b0000100000);
    cyc(1);
    chk("k5_pulse", {31'd0, key_valid}, 32'd0);
    cyc(20);
    chk("k5_hold", {22'd0, keypad}, 32'b0000100000);
    chk("k5_col", {29'd0, col_n}, 32'b101);
    chk("k5_once", vcount, 32'd1);
    pr = '0;
    cyc(4);
    chk("k5_rel_early", {22'd0, keypad}, 32'b0000100000);
    cyc(1);
    chk("k5_rel_keypad", {22'd0, keypad}, 32'd0);
    chk("k5_rel_code", {28'd0, key_code}, 32'hF);
    chk("k5_rel_col", {29'd0, col_n}, 32'b011);

    pr = k(3, 0);
    wait_valid("star");
    chk("star_code", {28'd0, key_code}, 32'd10);
    chk("star_keypad", {22'd0, keypad}, 32'd0);
    pr = '0;
    cyc(8);
    chk("star_rel", {28'd0, key_code}, 32'hF);
    pr = k(3, 1);
    wait_valid("k0");
    chk("k0_code", {28'd0, key_code}, 32'd0);
    chk("k0_keypad", {22'd0, keypad}, 32'd1);
    pr = '0;
    cyc(8);
    chk("k0_rel", {22'd0, keypad}, 32'd0);
    chk("valid_total", vcount, 32'd3);

    clear_n = 1'b0;
    cyc(1);
    clear_n = 1'b1;
    pr    = k(0, 2) | k(2, 2);
    vbase = vcount;
    trans = 0;
    prev  = col_n;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (col_n != prev) trans++;
      prev = col_n;
    end
    chk("multi_rotate", trans, 32'd10);
    chk("multi_novalid", vcount, vbase);
    chk("multi_keypad", {22'd0, keypad}, 32'd0);

    pr = k(2, 2);
    wait_valid("k9");
    chk("k9_code", {28'd0, key_code}, 32'd9);
    chk("k9_keypad", {22'd0, keypad}, 32'b1000000000);
    cyc(3);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_keypad", {22'd0, keypad}, 32'd0);
    chk("arst_code", {28'd0, key_code}, 32'hF);
    chk("arst_col", {29'd0, col_n}, 32'b110);
    pr = '0;
    @(negedge clk);
    clear_n = 1'b1;
    vbase = vcount;
    cyc(20);
    chk("arst_novalid", vcount, vbase);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
